// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants, derived totals
// and sync windows, coordinate width, and the sync-window decode helper.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    localparam int DEF_H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Sync level for a coordinate: active inside [start, stop), idle elsewhere.
    function automatic logic sync_level(input logic [COORD_W-1:0] pos,
                                        input logic [COORD_W-1:0] start,
                                        input logic [COORD_W-1:0] stop,
                                        input logic               active);
        return ((pos >= start) && (pos < stop)) ? active : ~active;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with enable; wrap flags the enabled cycle that rolls
// the count from MODULUS-1 back to zero.
module mod_counter #(
    parameter int MODULUS = 800,
    parameter int W       = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    assign wrap = en && (count == LAST);

    // Count on enable, rolling over at the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + W'(1);
    end
endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel/line counters advanced by the pixel
// tick, registered sync pulses aligned with the counters, and visible-area
// and end-of-line/frame strobes. Horizontal and vertical totals must each
// fit the 10-bit coordinate range (at most 1024).
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               line_end,
    output logic               frame_end
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic               h_wrap;
    logic               v_wrap;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;

    mod_counter #(.MODULUS(H_TOTAL), .W(COORD_W)) u_hcount (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .count (pixel_x),
        .wrap  (h_wrap)
    );

    mod_counter #(.MODULUS(V_TOTAL), .W(COORD_W)) u_vcount (
        .clk   (clk),
        .rst   (rst),
        .en    (h_wrap),
        .count (pixel_y),
        .wrap  (v_wrap)
    );

    // Values the counters will hold after this edge, so the sync flops
    // decode the same coordinates the counters are about to present.
    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (tick)
            x_next = h_wrap ? '0 : pixel_x + COORD_W'(1);
        if (h_wrap)
            y_next = v_wrap ? '0 : pixel_y + COORD_W'(1);
    end

    // Registered sync pulses loaded alongside the counters (no skew).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
        end else begin
            hsync <= sync_level(x_next, HS_START, HS_END, SYNC_ACTIVE);
            vsync <= sync_level(y_next, VS_START, VS_END, SYNC_ACTIVE);
        end
    end

    assign video_on  = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    assign line_end  = h_wrap;
    assign frame_end = v_wrap;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default 640x480 instance and a small-raster instance
// with active-high syncs share clk/rst/tick. A behavioural raster model pushes
// expected outputs per driven cycle; a monitor pops and compares them.
module tb_vga_sync;

    typedef struct packed {
        int   hd, hf, hsw, hb;
        int   vd, vf, vsw, vb;
        logic act;
    } cfg_t;

    typedef struct {
        logic [1:0]  sd;
        logic [1:0]  ss;
        logic [22:0] rd;
        logic [22:0] rs;
    } exp_t;

    localparam cfg_t CD = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    localparam cfg_t CS = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1};

    logic clk = 1'b0;
    logic rst;
    logic tick;

    logic       d_hs, d_vs, d_von, d_le, d_fe;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_von, s_le, s_fe;
    logic [9:0] s_x, s_y;

    int errors = 0;
    int checks = 0;
    int dx, dy, sx, sy;
    exp_t q[$];

    always #5 clk = ~clk;

    vga_sync dut_d (
        .clk(clk), .rst(rst), .tick(tick),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .pixel_x(d_x), .pixel_y(d_y),
        .line_end(d_le), .frame_end(d_fe)
    );

    vga_sync #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .tick(tick),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .pixel_x(s_x), .pixel_y(s_y),
        .line_end(s_le), .frame_end(s_fe)
    );

    function automatic int htot(input cfg_t c);
        return c.hd + c.hf + c.hsw + c.hb;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.vd + c.vf + c.vsw + c.vb;
    endfunction

    // Expected {x, y, hsync, vsync, video_on} at coordinate (x, y).
    function automatic logic [22:0] regs_of(input cfg_t c, input int x, input int y);
        logic hs, vs, von;
        hs  = (x >= c.hd + c.hf && x < c.hd + c.hf + c.hsw) ? c.act : ~c.act;
        vs  = (y >= c.vd + c.vf && y < c.vd + c.vf + c.vsw) ? c.act : ~c.act;
        von = (x < c.hd) && (y < c.vd);
        return {10'(x), 10'(y), hs, vs, von};
    endfunction

    task automatic adv(input cfg_t c, input logic t, inout int x, inout int y);
        if (t) begin
            if (x == htot(c) - 1) begin
                x = 0;
                y = (y == vtot(c) - 1) ? 0 : y + 1;
            end else begin
                x = x + 1;
            end
        end
    endtask

    // Drive tick for one cycle (from a falling edge) and queue the expectation.
    task automatic drive(input logic t);
        exp_t e;
        logic le;
        @(negedge clk);
        tick = t;
        le   = t && (dx == htot(CD) - 1);
        e.sd = {le, le && (dy == vtot(CD) - 1)};
        le   = t && (sx == htot(CS) - 1);
        e.ss = {le, le && (sy == vtot(CS) - 1)};
        adv(CD, t, dx, dy);
        adv(CS, t, sx, sy);
        e.rd = regs_of(CD, dx, dy);
        e.rs = regs_of(CS, sx, sy);
        q.push_back(e);
    endtask

    // Scoreboard monitor: strobes mid-low-phase, registers just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                checks += 2;
                if ({d_le, d_fe} !== q[0].sd) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL strobes_default got %b want %b at x=%0d y=%0d",
                                 {d_le, d_fe}, q[0].sd, d_x, d_y);
                end
                if ({s_le, s_fe} !== q[0].ss) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL strobes_small got %b want %b at x=%0d y=%0d",
                                 {s_le, s_fe}, q[0].ss, s_x, s_y);
                end
            end
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks += 2;
                if ({d_x, d_y, d_hs, d_vs, d_von} !== e.rd) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL regs_default got %h want %h",
                                 {d_x, d_y, d_hs, d_vs, d_von}, e.rd);
                end
                if ({s_x, s_y, s_hs, s_vs, s_von} !== e.rs) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL regs_small got %h want %h",
                                 {s_x, s_y, s_hs, s_vs, s_von}, e.rs);
                end
            end
        end
    end

    task automatic test_reset();
        rst  = 1'b1;
        tick = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tick = (i % 2 == 1);
            #1;
            checks += 2;
            if ({d_x, d_y, d_hs, d_vs, d_von, d_le, d_fe} !== {10'd0, 10'd0, 5'b11100}) begin
                errors++;
                $display("FAIL reset_default got %h want %h",
                         {d_x, d_y, d_hs, d_vs, d_von, d_le, d_fe}, {10'd0, 10'd0, 5'b11100});
            end
            if ({s_x, s_y, s_hs, s_vs, s_von, s_le, s_fe} !== {10'd0, 10'd0, 5'b00100}) begin
                errors++;
                $display("FAIL reset_small got %h want %h",
                         {s_x, s_y, s_hs, s_vs, s_von, s_le, s_fe}, {10'd0, 10'd0, 5'b00100});
            end
        end
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;
        dx = 0; dy = 0; sx = 0; sy = 0;
        drive(1'b0);
        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        @(posedge clk);
        #2;
        checks++;
        if (d_x !== 10'd1) begin
            errors++;
            $display("FAIL first_tick got x=%0d want 1", d_x);
        end
    endtask

    task automatic test_line();
        int   le_cnt = 0;
        int   fall_x = -1;
        int   rise_x = -1;
        int   von_x  = -1;
        logic phs, pvon;
        int   y0;
        logic done = 1'b0;
        phs  = d_hs;
        pvon = d_von;
        y0   = dy;
        for (int i = 0; i < 4000 && !done; i++) begin
            drive((i % 4) == 3);
            #2;
            if (d_le) le_cnt++;
            @(posedge clk);
            #2;
            if (phs && !d_hs) fall_x = int'(d_x);
            if (!phs && d_hs) rise_x = int'(d_x);
            if (pvon && !d_von) von_x = int'(d_x);
            phs  = d_hs;
            pvon = d_von;
            if (dy != y0) done = 1'b1;
        end
        checks += 6;
        if (!done) begin errors++; $display("FAIL line_budget got no wrap want wrap"); end
        if (fall_x != 656) begin errors++; $display("FAIL hsync_fall got x=%0d want 656", fall_x); end
        if (rise_x != 752) begin errors++; $display("FAIL hsync_rise got x=%0d want 752", rise_x); end
        if (von_x != 640) begin errors++; $display("FAIL video_off got x=%0d want 640", von_x); end
        if (le_cnt != 1) begin errors++; $display("FAIL line_end_count got %0d want 1", le_cnt); end
        if ({d_x, d_y} !== {10'd0, 10'd1}) begin
            errors++;
            $display("FAIL line_wrap got (%0d,%0d) want (0,1)", d_x, d_y);
        end
    endtask

    task automatic test_hold();
        logic [24:0] snap;
        logic        changed = 1'b0;
        for (int i = 0; i < 4000 && dx != 300; i++) begin
            drive((i % 4) == 3);
        end
        @(posedge clk);
        #2;
        checks++;
        if (d_x !== 10'd300) begin errors++; $display("FAIL hold_start got x=%0d want 300", d_x); end
        snap = {d_x, d_y, d_hs, d_vs, d_von, d_le, d_fe};
        for (int i = 0; i < 100; i++) begin
            drive(1'b0);
            #2;
            if ({d_x, d_y, d_hs, d_vs, d_von, d_le, d_fe} !== snap) changed = 1'b1;
            @(posedge clk);
            #2;
            if ({d_x, d_y, d_hs, d_vs, d_von, d_le, d_fe} !== snap) changed = 1'b1;
        end
        checks++;
        if (changed) begin errors++; $display("FAIL hold_frozen got change want frozen at %h", snap); end
    endtask

    task automatic test_back_to_back();
        int fe_cnt = 0;
        int vs_cnt = 0;
        int hs_cnt = 0;
        int origin = 0;
        logic fe;
        for (int i = 0; i < 196; i++) begin
            drive(1'b1);
            #2;
            fe = s_fe;
            if (fe) fe_cnt++;
            @(posedge clk);
            #2;
            if (s_vs) vs_cnt++;
            if (s_hs) hs_cnt++;
            if (fe && s_x == 10'd0 && s_y == 10'd0) origin++;
        end
        checks += 4;
        if (fe_cnt != 2) begin errors++; $display("FAIL small_frame_end got %0d want 2", fe_cnt); end
        if (vs_cnt != 28) begin errors++; $display("FAIL small_vsync_ticks got %0d want 28", vs_cnt); end
        if (hs_cnt != 28) begin errors++; $display("FAIL small_hsync_ticks got %0d want 28", hs_cnt); end
        if (origin != 2) begin errors++; $display("FAIL small_frame_origin got %0d want 2", origin); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 200 && !(sx == 11 && sy == 5); i++) begin
            drive(1'b1);
        end
        @(posedge clk);
        #2;
        checks++;
        if ({s_x, s_y, s_hs, s_vs} !== {10'd11, 10'd5, 2'b11}) begin
            errors++;
            $display("FAIL mid_reach got %h want %h", {s_x, s_y, s_hs, s_vs}, {10'd11, 10'd5, 2'b11});
        end
        #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if ({s_x, s_y, s_hs, s_vs, s_von, s_le, s_fe} !== {10'd0, 10'd0, 5'b00100}) begin
            errors++;
            $display("FAIL mid_reset_small got %h want %h",
                     {s_x, s_y, s_hs, s_vs, s_von, s_le, s_fe}, {10'd0, 10'd0, 5'b00100});
        end
        if ({d_x, d_y, d_hs, d_vs, d_von, d_le, d_fe} !== {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL mid_reset_default got %h want %h",
                     {d_x, d_y, d_hs, d_vs, d_von, d_le, d_fe}, {10'd0, 10'd0, 5'b11100});
        end
        repeat (3) @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;
        dx = 0; dy = 0; sx = 0; sy = 0;
        drive(1'b1);
        drive(1'b1);
        @(posedge clk);
        #2;
        checks++;
        if ({s_x, s_y, d_x, d_y} !== {10'd2, 10'd0, 10'd2, 10'd0}) begin
            errors++;
            $display("FAIL restart got %h want %h", {s_x, s_y, d_x, d_y}, {10'd2, 10'd0, 10'd2, 10'd0});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

VGA 640x480@60 Hz raster timing generator clocked at 100 MHz. Advances one pixel per cycle of the 25 MHz pixel-enable strobe from the pixel ticker and produces the horizontal/vertical sync pulses, visible-area flag and current pixel coordinates. The Pong renderer (paddles, ball, score) consumes these to colour each pixel.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hsync/vsync during the sync pulse
- clk  in  1  100 MHz system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  pixel enable, one clk cycle high every 4 clk cycles
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- line_end  out  1  strobe: tick high and pixel_x == H_TOTAL-1
- frame_end  out  1  strobe: line_end high and pixel_y == V_TOTAL-1

## Operation
- H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. Counters are 10-bit unsigned; all parameter sums must be ≤ 1024.
- Horizontal counter: on a clk edge with tick=1, increments; wraps H_TOTAL-1 -> 0. Holds when tick=0.
- Vertical counter: increments only on edges where the horizontal counter wraps; wraps V_TOTAL-1 -> 0 on the same edge, so (799,524) -> (0,0).
- hsync = SYNC_ACTIVE while H_DISPLAY+H_FRONT ≤ pixel_x < H_DISPLAY+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE.
- vsync = SYNC_ACTIVE while V_DISPLAY+V_FRONT ≤ pixel_y < V_DISPLAY+V_FRONT+V_SYNC (490..491), else ~SYNC_ACTIVE.
- hsync/vsync flops load the decode of the next counter values on the same edge as the counters, so they always match the decode of the current pixel_x/pixel_y (no skew).
- video_on, line_end, frame_end are combinational from counter registers and tick.
- tick stuck high: block counts every clk (legal, no special handling). tick stuck low: all outputs frozen.

## Timing
- Reset (asynchronous, immediate): pixel_x=0, pixel_y=0, hsync=vsync=~SYNC_ACTIVE, hence video_on=1, line_end=frame_end=0.
- First count advance on the first clk edge with tick=1 after rst deasserts.
- Count latency: pixel_x updates on the clk edge sampling tick=1; zero cycles between counter and sync outputs.
- line_end/frame_end high for exactly one clk cycle (the tick cycle) per line/frame.
- Reset mid-frame: counters and syncs return to reset values asynchronously; no partial-line recovery.
- With 4-clk tick: line = 3200 clk, frame = 1,680,000 clk (~59.5 Hz).

## Structure
- Shared package vga_timing_pkg: default 640x480 timing constants, derived H_TOTAL/V_TOTAL, sync start/end positions, coordinate width (10).
- One sub-module natural: mod_counter (parameter MODULUS; inputs clk, rst, en; outputs count, wrap), instantiated for horizontal (en=tick) and vertical (en=horizontal wrap).

## Test plan
- Assert rst, drive tick -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1 throughout reset; after release, first tick moves pixel_x to 1.
- Run one line with 4-clk tick -> hsync falls when pixel_x becomes 656, rises at 752; video_on falls at pixel_x=640; line_end single clk pulse at 799; pixel_y 0->1 at wrap.
- Run full frame -> vsync low exactly for pixel_y 490..491 (1600 ticks); frame_end single pulse at (799,524); next state (0,0); 420,000 ticks per frame.
- Hold tick low 100 clk mid-line at pixel_x=300 -> all outputs unchanged.
- Assert rst at (700,491) (hsync and vsync active) -> immediate return to reset values; clean restart from (0,0).
- Override parameters to a small raster (e.g. 8/2/2/2 × 4/1/1/1), SYNC_ACTIVE=1 -> sync windows, wrap points and polarity follow parameters.
